// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture controller: arms on a ctrl_arm rising edge, waits for a
// trigger, then streams valid input words into a BRAM port-A, either one-shot
// (fills the memory once) or circular (runs until a stop request).
module snapshot_capture_ctrl #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              trig,
    input  logic              ctrl_arm,
    input  logic              ctrl_trig_imm,
    input  logic              ctrl_circ,
    input  logic              ctrl_stop,
    output logic              bram_we,
    output logic              bram_en_a,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic [ADDR_W-1:0] status_addr,
    output logic [ADDR_W:0]   status_count,
    output logic              status_done,
    output logic              status_busy
);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    localparam logic [ADDR_W-1:0] PtrMax   = '1;
    localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic                arm_q;
    logic                circ_q, circ_d;
    logic                imm_q, imm_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   saddr_q, saddr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                done_q, done_d;
    logic                arm_edge;
    logic                wr;

    assign arm_edge = ctrl_arm & ~arm_q;

    // Next-state, write decision and status bookkeeping.
    always_comb begin
        state_d = state_q;
        circ_d  = circ_q;
        imm_d   = imm_q;
        wptr_d  = wptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        saddr_d = saddr_q;
        count_d = count_q;
        // done lags entry into StDone by one cycle so it follows the final write
        done_d  = done_q | (state_q == StDone);
        wr      = 1'b0;

        if (arm_edge) begin
            // Arm wins over any same-cycle trigger; mode bits latch only here.
            state_d = StArmed;
            circ_d  = ctrl_circ;
            imm_d   = ctrl_trig_imm;
            wptr_d  = '0;
            saddr_d = '0;
            count_d = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StArmed: begin
                    if (din_vld && (trig || imm_q)) begin
                        wr      = 1'b1;
                        state_d = StCapture;
                    end
                end
                StCapture: begin
                    if (din_vld) begin
                        wr = 1'b1;
                        if (!circ_q && (wptr_q == PtrMax)) begin
                            state_d = StDone;
                        end
                    end
                    if (ctrl_stop) begin
                        state_d = StDone;
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end

        if (wr) begin
            we_d    = 1'b1;
            addr_d  = wptr_q;
            wdata_d = din;
            saddr_d = wptr_q;
            wptr_d  = wptr_q + 1'b1;
            if (count_q != CountMax) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            arm_q   <= 1'b0;
            circ_q  <= 1'b0;
            imm_q   <= 1'b0;
            wptr_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            saddr_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= ctrl_arm;
            circ_q  <= circ_d;
            imm_q   <= imm_d;
            wptr_q  <= wptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            saddr_q <= saddr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Write data register; only meaningful while bram_we is high, so no reset.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    assign bram_we      = we_q;
    assign bram_en_a    = we_q;
    assign bram_addr    = addr_q;
    assign bram_wr_data = wdata_q;
    assign status_addr  = saddr_q;
    assign status_count = count_q;
    assign status_done  = done_q;
    assign status_busy  = (state_q == StArmed) || (state_q == StCapture);

endmodule

// File: tb/tb_snapshot_capture_ctrl.sv
// Bench for snapshot_capture_ctrl: randomized stimulus, a behavioural capture
// model, and a write scoreboard drained by an independent BRAM-port monitor.
module tb_snapshot_capture_ctrl;

    localparam int DW    = 128;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_vld = 1'b0, trig = 1'b0, ctrl_arm = 1'b0;
    logic          ctrl_trig_imm = 1'b0, ctrl_circ = 1'b0, ctrl_stop = 1'b0;
    logic          bram_we, bram_en_a, status_done, status_busy;
    logic [AW-1:0] bram_addr, status_addr;
    logic [DW-1:0] bram_wr_data;
    logic [AW:0]   status_count;

    snapshot_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .din_vld       (din_vld),
        .trig          (trig),
        .ctrl_arm      (ctrl_arm),
        .ctrl_trig_imm (ctrl_trig_imm),
        .ctrl_circ     (ctrl_circ),
        .ctrl_stop     (ctrl_stop),
        .bram_we       (bram_we),
        .bram_en_a     (bram_en_a),
        .bram_addr     (bram_addr),
        .bram_wr_data  (bram_wr_data),
        .status_addr   (status_addr),
        .status_count  (status_count),
        .status_done   (status_done),
        .status_busy   (status_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Model: where the capture stands, expressed as flags and integer counters.
    bit m_prev_arm = 0, m_armed = 0, m_capturing = 0, m_finished = 0;
    bit m_circ = 0, m_imm = 0;
    int m_ptr = 0, m_count = 0, m_last = 0;
    bit m_we = 0, m_done = 0, m_busy = 0;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void model_write(logic [DW-1:0] d);
        wr_t w;
        w.addr = m_ptr[AW-1:0];
        w.data = d;
        exp_q.push_back(w);
        m_we    = 1;
        m_last  = m_ptr;
        m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
        if (!m_circ && m_ptr == DEPTH - 1) begin
            m_capturing = 0;
            m_finished  = 1;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
    endfunction

    // Expected outputs after the coming clock edge for the inputs just applied.
    function automatic void model_update(bit r, bit a, bit t, bit v, bit s, bit c, bit im,
                                         logic [DW-1:0] d);
        bit edge_seen, was_finished;
        m_we = 0;
        if (r) begin
            m_prev_arm = 0; m_armed = 0; m_capturing = 0; m_finished = 0;
            m_ptr = 0; m_count = 0; m_last = 0; m_done = 0; m_busy = 0;
            return;
        end
        edge_seen    = a && !m_prev_arm;
        m_prev_arm   = a;
        was_finished = m_finished;
        if (edge_seen) begin
            m_armed = 1; m_capturing = 0; m_finished = 0;
            m_ptr = 0; m_count = 0; m_last = 0; m_circ = c; m_imm = im;
        end else if (m_armed) begin
            if (v && (t || m_imm)) begin
                m_armed = 0; m_capturing = 1;
                model_write(d);
            end
        end else if (m_capturing) begin
            if (v) model_write(d);
            if (s) begin
                m_capturing = 0; m_finished = 1;
            end
        end
        // done follows the capture having finished by one cycle
        m_done = !edge_seen && (m_done || was_finished);
        m_busy = m_armed || m_capturing;
    endfunction

    task automatic step(bit r, bit a, bit t, bit v, bit s, bit c, bit im, logic [DW-1:0] d);
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("bram_we", {127'd0, bram_we}, {127'd0, m_we});
            check("status_done", {127'd0, status_done}, {127'd0, m_done});
            check("status_busy", {127'd0, status_busy}, {127'd0, m_busy});
            check("status_count", DW'(status_count), DW'(m_count));
            check("status_addr", DW'(status_addr), DW'(m_last));
        end
        rst = r; ctrl_arm = a; trig = t; din_vld = v; ctrl_stop = s;
        ctrl_circ = c; ctrl_trig_imm = im; din = d;
        model_update(r, a, t, v, s, c, im, d);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, rnd_word());
    endtask

    // Monitor: every BRAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (chk_en) begin
            if (bram_we === 1'b1) begin
                check("bram_en_a_on_write", {127'd0, bram_en_a}, {127'd0, 1'b1});
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {116'd0, bram_addr}, '1);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("bram_addr", DW'(bram_addr), DW'(w.addr));
                    check("bram_wr_data", bram_wr_data, w.data);
                end
            end else begin
                check("bram_en_a_idle", {127'd0, bram_en_a}, {127'd0, 1'b0});
            end
        end
    end

    initial begin
        int guard;
        // Reset and reset-state checks.
        step(1, 0, 0, 0, 0, 0, 0, '0);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, 0, '0);
        check("rst_we", {127'd0, bram_we}, '0);
        check("rst_addr", DW'(bram_addr), '0);
        check("rst_count", DW'(status_count), '0);
        check("rst_done", {127'd0, status_done}, '0);
        check("rst_busy", {127'd0, status_busy}, '0);
        // Stop and trigger while idle are ignored.
        step(0, 0, 1, 1, 1, 0, 0, rnd_word());
        idle(2);

        // One-shot fill, trigger pulsed on word value 5.
        step(0, 1, 0, 1, 0, 0, 0, DW'(0));
        for (int k = 1; k <= 5 + DEPTH + 3; k++)
            step(0, 0, (k == 5) || (k > 5 && $urandom_range(0, 1) == 1), 1,
                 0, $urandom_range(0, 1), 0, DW'(k));
        idle(3);
        check("oneshot_count", DW'(status_count), DW'(DEPTH));
        check("oneshot_addr", DW'(status_addr), DW'(DEPTH - 1));
        check("oneshot_done", {127'd0, status_done}, DW'(1));

        // Immediate trigger, gappy valid, mode inputs wiggled while busy.
        step(0, 1, 0, 0, 0, 0, 1, rnd_word());
        guard = 0;
        while (!m_finished && guard < 20000) begin
            step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0,
                 $urandom_range(0, 1), $urandom_range(0, 1), rnd_word());
            guard++;
        end
        check("imm_finished_in_budget", DW'(guard < 20000), DW'(1));
        for (int k = 0; k < 6; k++) step(0, 0, 1, 1, 0, 0, 1, rnd_word());
        idle(2);
        check("imm_done", {127'd0, status_done}, DW'(1));

        // Circular: 5000 words then stop.
        step(0, 1, 0, 0, 0, 1, 0, rnd_word());
        for (int k = 0; k < 5000; k++) step(0, 0, k == 0, 1, 0, 0, 0, rnd_word());
        step(0, 0, 0, 0, 1, 0, 0, rnd_word());
        idle(3);
        check("circ_addr", DW'(status_addr), DW'(903));
        check("circ_count", DW'(status_count), DW'(DEPTH));
        check("circ_done", {127'd0, status_done}, DW'(1));

        // Arm and trigger together, stop ignored while armed, trigger 3 later.
        step(0, 1, 1, 1, 0, 0, 0, rnd_word());
        step(0, 0, 0, 1, 1, 0, 0, rnd_word());
        step(0, 0, 0, 1, 0, 0, 0, rnd_word());
        step(0, 0, 1, 1, 0, 0, 0, rnd_word());
        step(0, 0, 0, 0, 0, 0, 0, rnd_word());
        check("armtrig_first_addr", DW'(status_addr), '0);
        check("armtrig_first_count", DW'(status_count), DW'(1));
        for (int k = 0; k < 10; k++) step(0, 0, 0, $urandom_range(0, 1), 0, 0, 0, rnd_word());
        step(0, 0, 0, 1, 1, 0, 0, rnd_word());
        idle(3);

        // Arm held through reset, reset mid-capture, then restart.
        step(1, 1, 0, 0, 0, 0, 0, rnd_word());
        step(1, 1, 0, 0, 0, 0, 0, rnd_word());
        step(0, 1, 0, 0, 0, 0, 0, rnd_word());
        for (int k = 0; k < 100; k++) step(0, 1, k == 0, 1, 0, 0, 0, rnd_word());
        step(1, 1, 0, 1, 0, 0, 0, rnd_word());
        step(0, 1, 0, 0, 0, 0, 0, rnd_word());
        check("midrst_we", {127'd0, bram_we}, '0);
        check("midrst_count", DW'(status_count), '0);
        check("midrst_busy", {127'd0, status_busy}, '0);
        for (int k = 0; k < 20; k++) step(0, 1, k == 2, 1, 0, 0, 0, rnd_word());
        step(0, 0, 0, 0, 1, 0, 0, rnd_word());
        idle(3);
        check("restart_count", DW'(status_count), DW'(20 - 2));
        check("scoreboard_drained", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
